word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Transmit side of the team's parallel-to-narrow stream link.
- Accepts one DATA_WIDTH-bit word over a valid/ready input handshake and emits it as NUM_SLICES consecutive SLICE_WIDTH-bit slices, LSB slice first, on a valid/ready output stream.
- Flags the final slice of each word with out_last.
- Counterpart of the link's deserializer; that block, bound with its property module, is the equivalence/loopback target.

Parameters:
- DATA_WIDTH, 32, width of the parallel input word.
- SLICE_WIDTH, 8, width of each output slice. DATA_WIDTH mod SLICE_WIDTH must be 0.
- NUM_SLICES, DATA_WIDTH/SLICE_WIDTH, derived; must be >= 2. Any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_WIDTH  parallel word; sampled only on in_valid && in_ready.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  downstream accepts the slice.
- out_data  output  SLICE_WIDTH  current slice.
- out_last  output  1  current slice is slice NUM_SLICES-1 of its word.
- busy  output  1  high while a word is in flight (state SEND).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, slice counter=0, shift register=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, in_ready=0 while rst is high.
  - A word in flight is discarded, with no partial output after release.
- State IDLE:
  - in_ready=1.
  - On in_valid: load shift register with in_data, counter=0, go to SEND.
- State SEND:
  - out_valid=1, busy=1.
  - out_data = shift register [SLICE_WIDTH-1:0].
  - out_last = (counter == NUM_SLICES-1).
- Output handshake (out_valid && out_ready):
  - Not last: shift register right by SLICE_WIDTH (zero fill), counter+1.
  - Last, with in_valid high: load the new word, counter=0, stay in SEND (back-to-back).
  - Last, with in_valid low: go to IDLE, out_data returns to 0.
- in_ready in SEND = out_ready && out_last, combinational from out_ready. There is no other combinational input-to-output path.
- Latency: word accepted at edge N; first slice valid in the cycle after edge N; out_last asserted in the cycle after edge N+NUM_SLICES-1 if out_ready is held high.
- Throughput: one slice per cycle with out_ready held high; no bubble between words when in_valid stays high.
- Stability: while out_valid && !out_ready, out_data and out_last hold; out_valid never drops without a handshake (except reset).
- Counter width: clog2(NUM_SLICES); never exceeds NUM_SLICES-1; wraps to 0 only via a word load.
- in_valid/in_data are ignored outside in_valid && in_ready; the input side need not hold them stable.
- Rst high overrides all simultaneous events.

Test Plan:
- Single word: reset, then in_data=32'hDDCCBBAA with out_ready=1 -> slices AA,BB,CC,DD on 4 consecutive cycles starting one cycle after accept; out_last only with DD; busy returns to 0 after; out_data=0.
- Back-to-back: 32'h44332211 then 32'h88776655 presented continuously with out_ready=1 -> 8 consecutive slices 11..88 with no gap; in_ready pulses high exactly in the cycle 44 is accepted; out_last high on 44 and 88.
- Backpressure: out_ready=0 for 5 cycles while slice BB is shown -> out_data=BB, out_valid=1, out_last=0 held stable; resumes CC on release; in_ready=0 throughout.
- Input ignored while busy: in_valid=1 with in_data=32'hFFFFFFFF during slices 0-2 of 32'h03020100 -> output 00,01,02,03 unchanged; FFFFFFFF is accepted only at the last-slice handshake and then emitted as FF x4.
- Reset mid-word: assert rst asynchronously between clock edges after slice 01 of 32'h03020100 -> out_valid/out_last/busy drop immediately; no further slices after release; next word 32'hA5A5A5A5 serializes cleanly from slice 0.
- Randomized loopback vs deserializer: random in_valid/out_ready, 1000 words -> every word reconstructed exactly, in order.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer
// Transmit side of the parallel-to-narrow stream link. Takes one DATA_WIDTH
// word over a valid/ready handshake and emits it as NUM_SLICES slices of
// SLICE_WIDTH bits, LSB slice first, flagging the final slice with out_last.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept a word this cycle
//   in_data    parallel input word
//   out_valid  out_data/out_last valid
//   out_ready  downstream accepts the slice
//   out_data   current slice
//   out_last   current slice is the final slice of its word
//   busy       a word is in flight
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no word held; in_ready high, waiting for in_valid
// SEND   | presenting slices of the held word, LSB slice first

module word_serializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int SLICE_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SLICE_WIDTH-1:0] out_data,
   output logic                   out_last,
   output logic                   busy
);

   localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

   generate
      if ((DATA_WIDTH % SLICE_WIDTH) != 0 || NUM_SLICES < 2) begin : g_bad_params
         $error("word_serializer: DATA_WIDTH must be a multiple of SLICE_WIDTH with at least 2 slices");
      end
   endgenerate

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  is_last;
   logic                  in_hs;
   logic                  out_hs;

   assign is_last = (cnt == LAST_CNT);
   assign in_hs   = in_valid && in_ready;
   assign out_hs  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (out_hs && is_last && !in_valid) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // in_ready is masked by rst so nothing is accepted while reset is held,
   // even though the async reset has already forced the state to IDLE.
   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      busy      = 1'b0;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = !rst;
         end
         S_SEND: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            out_data  = shreg[SLICE_WIDTH-1:0];
            out_last  = is_last;
            in_ready  = out_ready && is_last && !rst;
         end
         default: ;
      endcase
   end

   // A word load takes priority: in SEND it can only coincide with the
   // last-slice handshake, which is what makes back-to-back words gapless.
   // After the last slice without a new word the counter simply holds; it
   // only returns to 0 through the next load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (in_hs) begin
         shreg <= in_data;
         cnt   <= '0;
      end else if (out_hs && !is_last) begin
         shreg <= shreg >> SLICE_WIDTH;
         cnt   <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Testbench for word_serializer: directed scenarios followed by randomized
// valid/ready traffic, checked cycle by cycle against a queue-based model
// of the pending slices and a reassembling deserializer model.

module tb_word_serializer;

   localparam int DW = 32;
   localparam int SW = 8;
   localparam int NS = DW / SW;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_data;
   logic          out_last;
   logic          busy;

   word_serializer #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] d;
      logic          l;
   } slice_t;

   slice_t        sq[$];
   logic [DW-1:0] wq[$];
   logic [DW-1:0] acc;
   int            idx;
   int            n_checks;
   int            n_errors;
   int            words_done;

   task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      sq.delete();
      wq.delete();
      acc = '0;
      idx = 0;
   endtask

   // One clock cycle: drive inputs after the falling edge, compare outputs
   // with the model, then advance the model by the handshakes that will
   // complete at the next rising edge.
   task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy);
      logic exp_busy;
      logic exp_ir;
      slice_t s;
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      #1;
      exp_busy = (sq.size() != 0);
      check_val("out_valid", DW'(out_valid), DW'(exp_busy));
      check_val("busy", DW'(busy), DW'(exp_busy));
      if (exp_busy) begin
         check_val("out_data", DW'(out_data), DW'(sq[0].d));
         check_val("out_last", DW'(out_last), DW'(sq[0].l));
         exp_ir = ordy && sq[0].l;
      end else begin
         check_val("idle_out_data", DW'(out_data), '0);
         check_val("idle_out_last", DW'(out_last), '0);
         exp_ir = 1'b1;
      end
      check_val("in_ready", DW'(in_ready), DW'(exp_ir));
      if (exp_busy && ordy) begin
         s = sq.pop_front();
         acc = acc | (DW'(s.d) << (idx * SW));
         idx++;
         if (s.l) begin
            check_val("slices_per_word", DW'(idx), DW'(NS));
            if (wq.size() != 0) begin
               check_val("loopback_word", acc, wq.pop_front());
            end else begin
               check_val("loopback_unexpected_word", acc, ~acc);
            end
            acc = '0;
            idx = 0;
            words_done++;
         end
      end
      if (iv && exp_ir) begin
         wq.push_back(id);
         for (int k = 0; k < NS; k++) begin
            s.d = id[k*SW +: SW];
            s.l = (k == NS - 1);
            sq.push_back(s);
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_out_valid"}, DW'(out_valid), '0);
      check_val({tag, "_out_last"}, DW'(out_last), '0);
      check_val({tag, "_out_data"}, DW'(out_data), '0);
      check_val({tag, "_busy"}, DW'(busy), '0);
      check_val({tag, "_in_ready"}, DW'(in_ready), '0);
   endtask

   initial begin
      int target;
      int cyc;
      n_checks   = 0;
      n_errors   = 0;
      words_done = 0;
      model_clear();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // single word
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      for (int i = 0; i < NS + 2; i++) step(1'b0, 32'h0, 1'b1);

      // back-to-back words, no gap
      step(1'b1, 32'h44332211, 1'b1);
      for (int i = 0; i < NS; i++) step(1'b1, 32'h88776655, 1'b1);
      for (int i = 0; i < NS + 1; i++) step(1'b0, 32'h0, 1'b1);

      // backpressure on slice BB
      step(1'b1, 32'hDDCCBBAA, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
      for (int i = 0; i < NS; i++) step(1'b0, 32'h0, 1'b1);

      // input presented while busy is ignored until the last slice
      step(1'b1, 32'h03020100, 1'b1);
      for (int i = 0; i < NS; i++) step(1'b1, 32'hFFFFFFFF, 1'b1);
      for (int i = 0; i < NS + 1; i++) step(1'b0, 32'h0, 1'b1);

      // asynchronous reset mid-word, after slice 01
      step(1'b1, 32'h03020100, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("midword_reset");
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
      step(1'b1, 32'hA5A5A5A5, 1'b1);
      for (int i = 0; i < NS + 1; i++) step(1'b0, 32'h0, 1'b1);

      // randomized traffic, 1000 words reassembled in order
      target = words_done + 1000;
      cyc = 0;
      while (words_done < target && cyc < 40000) begin
         step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0);
         cyc++;
      end
      check_val("random_words_done", DW'(words_done >= target), DW'(1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
